// File: rtl/key_matrix_scan_if.sv
// Key event stream between the keypad scanner and its consumer.
//
// Signals:
//   evt_valid  head event presented (event FIFO not empty)
//   evt_ready  consumer accepts the head event while evt_valid is high
//   evt_code   key code of the head event, r*COLS+c
//   evt_press  1 = press event, 0 = release event
//
// Modports:
//   master  event producer (the scanner)
//   slave   event consumer
interface key_matrix_scan_if #(
  parameter int unsigned CW = 4
) ();

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_code;
  logic          evt_press;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    output evt_ready
  );

endinterface

// File: rtl/key_matrix_scan.sv
// Parametrised matrix keypad scanner.
//
// Drives the matrix columns active-low one at a time, dwelling T1MS clocks on each. At the end of
// every dwell the synchronised rows are snapshotted, and in the following ROWS cycles each row of
// the snapshot is run through a per-key debouncer, one key per cycle. A key changes state only
// after DEBOUNCE consecutive frame samples that disagree with its current state; every change
// pushes a press/release event into a show-ahead FIFO read over a valid/ready stream.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   row         matrix row inputs, active-low, asynchronous to clk
//   col         matrix column drive, one-hot active-low (all ones in reset)
//   evt         event stream (master modport): evt_valid/evt_ready/evt_code/evt_press
//   key_state   debounced key bitmap, bit r*COLS+c set while the key is held
//   fifo_count  number of events held in the FIFO
//   overflow    sticky flag: an event was dropped because the FIFO was full
//   ovf_clr     clears overflow (a simultaneous drop keeps it set)
module key_matrix_scan #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned T1MS       = 50000,
  parameter int unsigned DEBOUNCE   = 20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  key_matrix_scan_if.master             evt,
  output logic [ROWS*COLS-1:0]          key_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned NK  = ROWS * COLS;
  localparam int unsigned CW  = $clog2(NK);
  localparam int unsigned DW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TW  = $clog2(T1MS);
  localparam int unsigned IW  = $clog2(COLS);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = PW + 1;
  localparam int unsigned EW  = CW + 1;

  // --------------------------------------------------------------------------------------------
  // Column scan and row capture
  // --------------------------------------------------------------------------------------------
  logic [ROWS-1:0] row_meta_q, row_sync_q;
  logic [ROWS-1:0] row_snap_q;
  logic [IW-1:0]   c_snap_q;
  logic [IW-1:0]   col_idx_q, col_idx_d;
  logic [TW-1:0]   dwell_q, dwell_d;
  logic [COLS-1:0] col_q;
  logic            dwell_end;

  always_comb begin
    dwell_end = (dwell_q == TW'(T1MS - 1));
    dwell_d   = dwell_q + 1'b1;
    col_idx_d = col_idx_q;
    if (dwell_end) begin
      dwell_d = '0;
      if (col_idx_q == IW'(COLS - 1)) begin
        col_idx_d = '0;
      end else begin
        col_idx_d = col_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      // An all-released snapshot makes the serial pass before the first capture a no-op.
      row_snap_q <= '1;
      c_snap_q   <= '0;
      col_idx_q  <= '0;
      dwell_q    <= '0;
      col_q      <= '1;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      // Column drive follows the index one edge late, so a new column appears on the edge
      // after the capture that advanced the index.
      col_q      <= ~(COLS'(1) << col_idx_q);
      if (dwell_end) begin
        row_snap_q <= row_sync_q;
        c_snap_q   <= col_idx_q;
      end
    end
  end

  assign col = col_q;

  // --------------------------------------------------------------------------------------------
  // Serial per-key debounce: row r of the snapshot is handled at dwell count r
  // --------------------------------------------------------------------------------------------
  logic [NK-1:0]  key_state_q;
  logic [DW-1:0]  cnt_q [NK];
  logic           proc_en;
  logic [RW-1:0]  proc_row;
  logic [CW-1:0]  proc_key;
  logic           raw;
  logic           cur_state;
  logic [DW-1:0]  cur_cnt;
  logic [DW-1:0]  cnt_nxt;
  logic           toggle;

  always_comb begin
    proc_en   = (dwell_q < TW'(ROWS));
    proc_row  = RW'(dwell_q);
    proc_key  = CW'(int'(proc_row) * COLS + int'(c_snap_q));
    raw       = ~row_snap_q[proc_row];
    cur_state = key_state_q[proc_key];
    cur_cnt   = cnt_q[proc_key];
    cnt_nxt   = '0;
    toggle    = 1'b0;
    // A sample that agrees with the debounced state leaves cnt_nxt at zero, restarting the run.
    if (proc_en && (raw != cur_state)) begin
      if (cur_cnt == DW'(DEBOUNCE - 1)) begin
        toggle = 1'b1;
      end else begin
        cnt_nxt = cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_q <= '0;
      for (int unsigned i = 0; i < NK; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (proc_en) begin
      cnt_q[proc_key] <= cnt_nxt;
      if (toggle) begin
        key_state_q[proc_key] <= raw;
      end
    end
  end

  assign key_state = key_state_q;

  // --------------------------------------------------------------------------------------------
  // Show-ahead event FIFO
  // --------------------------------------------------------------------------------------------
  logic [EW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0] count_q, count_d;
  logic           ovf_q;
  logic           push, pop, full, empty, wr_en, drop;
  logic [EW-1:0]  push_data;
  logic [EW-1:0]  head;

  always_comb begin
    push      = toggle;
    push_data = {proc_key, raw};
    full      = (count_q == FCW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    pop       = !empty && evt.evt_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      fifo_mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign head          = empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign evt.evt_valid = !empty;
  assign evt.evt_code  = head[EW-1:1];
  assign evt.evt_press = head[0];
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan (4x4, T1MS=50, DEBOUNCE=3, FIFO_DEPTH=8).
// A behavioural matrix model shorts row r to col c while key r*4+c is held.
module tb_key_matrix_scan;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned T1MS  = 50;
  localparam int unsigned DEB   = 3;
  localparam int unsigned FD    = 8;
  localparam int          FRAME = COLS * T1MS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_state;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] keys = '0;

  key_matrix_scan_if #(.CW(4)) evt_bus ();

  key_matrix_scan #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .T1MS       (T1MS),
    .DEBOUNCE   (DEB),
    .FIFO_DEPTH (FD)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .evt        (evt_bus),
    .key_state  (key_state),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
      end
    end
  end

  // Edge index since reset release: the first non-reset edge leaves cyc = 1.
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [4:0] got[$];
  always @(negedge clk) begin
    if (evt_bus.evt_valid && evt_bus.evt_ready) got.push_back({evt_bus.evt_code, evt_bus.evt_press});
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [4:0] ev(input int code, input logic press);
    return {4'(code), press};
  endfunction

  task automatic run_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  // Wait for frame phase 10: no column capture is within 40 cycles of this point.
  task automatic align();
    while (cyc % FRAME != 10) @(posedge clk);
    #1;
  endtask

  task automatic check_events(input string tag, input int n, input logic [2:0][4:0] exp_ev);
    check({tag, " event count"}, 32'(got.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s event %0d", tag, j),
            (j < got.size()) ? 32'(got[j]) : 32'hdead, 32'(exp_ev[j]));
    end
  endtask

  typedef struct packed {
    logic [15:0]     keys;
    logic [7:0]      frames;
    logic [15:0]     exp_state;
    logic [1:0]      exp_n;
    logic [2:0][4:0] exp_ev;
  } step_t;

  function automatic step_t mk(input logic [15:0] k, input int fr, input logic [15:0] st,
                               input int n, input logic [4:0] e0, input logic [4:0] e1,
                               input logic [4:0] e2);
    step_t s;
    s.keys      = k;
    s.frames    = 8'(fr);
    s.exp_state = st;
    s.exp_n     = 2'(n);
    s.exp_ev[0] = e0;
    s.exp_ev[1] = e1;
    s.exp_ev[2] = e2;
    return s;
  endfunction

  localparam int NSTEP = 18;
  step_t tbl [NSTEP];

  initial begin
    logic [2:0][4:0] exp3;

    tbl[0]  = mk(16'h0200, 2, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[1]  = mk(16'h0200, 1, 16'h0200, 1, ev(9, 1), 5'h0, 5'h0);
    tbl[2]  = mk(16'h0200, 7, 16'h0200, 0, 5'h0, 5'h0, 5'h0);
    tbl[3]  = mk(16'h0000, 2, 16'h0200, 0, 5'h0, 5'h0, 5'h0);
    tbl[4]  = mk(16'h0000, 1, 16'h0000, 1, ev(9, 0), 5'h0, 5'h0);
    tbl[5]  = mk(16'h0400, 2, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[6]  = mk(16'h0000, 3, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[7]  = mk(16'h0400, 2, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[8]  = mk(16'h0000, 1, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[9]  = mk(16'h0400, 2, 16'h0000, 0, 5'h0, 5'h0, 5'h0);
    tbl[10] = mk(16'h0400, 1, 16'h0400, 1, ev(10, 1), 5'h0, 5'h0);
    tbl[11] = mk(16'h0000, 3, 16'h0000, 1, ev(10, 0), 5'h0, 5'h0);
    tbl[12] = mk(16'h8001, 3, 16'h8001, 2, ev(0, 1), ev(15, 1), 5'h0);
    tbl[13] = mk(16'h8021, 3, 16'h8021, 1, ev(5, 1), 5'h0, 5'h0);
    tbl[14] = mk(16'h8020, 3, 16'h8020, 1, ev(0, 0), 5'h0, 5'h0);
    tbl[15] = mk(16'h0000, 3, 16'h0000, 2, ev(5, 0), ev(15, 0), 5'h0);
    tbl[16] = mk(16'h0118, 3, 16'h0118, 3, ev(4, 1), ev(8, 1), ev(3, 1));
    tbl[17] = mk(16'h0000, 3, 16'h0000, 3, ev(4, 0), ev(8, 0), ev(3, 0));

    evt_bus.evt_ready = 1'b0;

    // Reset state and column timing
    repeat (10) @(posedge clk);
    #1;
    check("reset col", 32'(col), 32'hf);
    check("reset evt_valid", 32'(evt_bus.evt_valid), 32'h0);
    check("reset evt_code", 32'(evt_bus.evt_code), 32'h0);
    check("reset key_state", 32'(key_state), 32'h0);
    check("reset fifo_count", 32'(fifo_count), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first col", 32'(col), 32'he);
    repeat (T1MS) @(posedge clk);
    #1;
    check("second col", 32'(col), 32'hd);
    align();

    // Directed key sequences
    evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < NSTEP; i++) begin
      got.delete();
      keys = tbl[i].keys;
      run_frames(int'(tbl[i].frames));
      check($sformatf("step%0d key_state", i), 32'(key_state), 32'(tbl[i].exp_state));
      check_events($sformatf("step%0d", i), int'(tbl[i].exp_n), tbl[i].exp_ev);
    end

    // Overflow: 5 presses + 5 releases into an 8-deep FIFO with no consumer
    evt_bus.evt_ready = 1'b0;
    keys = 16'h08c6;
    run_frames(3);
    check("ovf presses count", 32'(fifo_count), 32'd5);
    check("ovf presses flag", 32'(overflow), 32'h0);
    keys = 16'h0000;
    run_frames(3);
    check("ovf full count", 32'(fifo_count), 32'd8);
    check("ovf flag set", 32'(overflow), 32'h1);
    check("ovf key_state", 32'(key_state), 32'h0);
    check("ovf head", 32'({evt_bus.evt_valid, evt_bus.evt_code, evt_bus.evt_press}), 32'h23);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf cleared", 32'(overflow), 32'h0);
    check("ovf count after clr", 32'(fifo_count), 32'd8);
    got.delete();
    evt_bus.evt_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("drain count", 32'(got.size()), 32'd8);
    begin
      logic [4:0] drain_exp [8];
      drain_exp = '{ev(1, 1), ev(2, 1), ev(6, 1), ev(7, 1), ev(11, 1), ev(1, 0), ev(2, 0), ev(6, 0)};
      for (int j = 0; j < 8; j++) begin
        check($sformatf("drain event %0d", j),
              (j < got.size()) ? 32'(got[j]) : 32'hdead, 32'(drain_exp[j]));
      end
    end
    check("drain empty", 32'({evt_bus.evt_valid, fifo_count}), 32'h0);
    align();

    // Reset in the middle of a serial update with 3 events queued
    evt_bus.evt_ready = 1'b0;
    keys = 16'h0046;
    run_frames(3);
    check("pre-rst count", 32'(fifo_count), 32'd3);
    check("pre-rst key_state", 32'(key_state), 32'h0046);
    repeat (T1MS - 9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-rst count", 32'(fifo_count), 32'd0);
    check("mid-rst evt_valid", 32'(evt_bus.evt_valid), 32'h0);
    check("mid-rst key_state", 32'(key_state), 32'h0);
    check("mid-rst col", 32'(col), 32'hf);
    rst = 1'b0;
    align();
    got.delete();
    evt_bus.evt_ready = 1'b1;
    run_frames(DEB - 1);
    check("re-reg early key_state", 32'(key_state), 32'h0);
    check("re-reg early events", 32'(got.size()), 32'd0);
    run_frames(1);
    check("re-reg key_state", 32'(key_state), 32'h0046);
    exp3[0] = ev(1, 1);
    exp3[1] = ev(2, 1);
    exp3[2] = ev(6, 1);
    check_events("re-reg", 3, exp3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
Parametrised matrix keypad scanner, the successor of the 4x4 single-key key_pad. It drives ROWS x COLS matrix columns active-low one at a time and debounces every key independently, so multiple keys may be held at once. It emits press and release events through a FIFO with a valid/ready interface and exposes a live debounced key bitmap. It sits between the board keypad pins and the control logic that consumes key codes.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
T1MS, 50000, clk cycles per column dwell (1 ms at 50 MHz); must be >= ROWS+4
DEBOUNCE, 20, consecutive differing frame samples required to change a key's state (>= 1)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
row  in  ROWS  matrix row inputs, active-low, asynchronous to clk
col  out  COLS  matrix column drive, one-hot active-low
evt_valid  out  1  FIFO not empty; head event presented
evt_ready  in  1  consumer accepts head event when evt_valid=1
evt_code  out  CW  key code of head event = r*COLS+c; CW = clog2(ROWS*COLS)
evt_press  out  1  1 = press event, 0 = release event
key_state  out  ROWS*COLS  debounced state, bit r*COLS+c = 1 while key held
fifo_count  out  clog2(FIFO_DEPTH)+1  entries in FIFO
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (clk edge with rst=1): col = all ones, evt_valid=0, evt_code=0, evt_press=0, key_state=0, fifo_count=0, overflow=0; all debounce counters, the dwell counter and the column index = 0; FIFO emptied. Reset wins over every other event, including mid-serial-processing; pending events are discarded.
- First cycle after reset: col[0]=0, other bits 1.
- row passes a 2-flop synchroniser before use.
- Dwell counter counts 0..T1MS-1 per column. At count T1MS-1: the synchronised row is captured into row_snap together with the current column index c_snap; the column index advances (COLS-1 wraps to 0); col switches on the next edge. One frame = COLS*T1MS cycles.
- Serial update: in the ROWS cycles after capture (dwell counts 0..ROWS-1), row r = 0..ROWS-1 is processed one per cycle for key k = r*COLS+c_snap. raw = ~row_snap[r].
- Debounce per key, counter width clog2(DEBOUNCE): raw == key_state[k] -> cnt=0. raw != key_state[k] and cnt < DEBOUNCE-1 -> cnt+1. raw != key_state[k] and cnt == DEBOUNCE-1 -> key_state[k] toggles, cnt=0, push {code=k, press=raw}.
- A press therefore registers on the DEBOUNCE-th consecutive asserted sample of that key (one sample per frame). Any single matching sample restarts the count.
- Event order within a frame: ascending column, then ascending row.
- FIFO is show-ahead: evt_code/evt_press are valid whenever evt_valid=1; pop on evt_valid & evt_ready. Outputs hold while evt_ready=0.
- Push while full without a simultaneous pop: event dropped, overflow set to 1; key_state is still updated. Push and pop in the same cycle when full: both happen, count unchanged, no overflow. When empty, a pushed event is visible the next cycle (evt_valid=1).
- ovf_clr=1 clears overflow; if a drop occurs in the same cycle, overflow stays 1 (set wins).
- evt_ready while evt_valid=0 has no effect.

Test Plan:
- Reset: T1MS=50, DEBOUNCE=3, rst=1 for 10 cycles -> col=4'b1111, evt_valid=0, key_state=0; first cycle after rst falls, col=4'b1110, then 4'b1101 50 cycles later.
- Single key: a bench model shorts row[2] to col[1] (key 9) for 10 frames with evt_ready=1 -> exactly one press event, code 9, press=1, on the 3rd frame sample; key_state[9]=1. Releasing gives one release event, code 9, press=0, 3 frames later.
- Bounce: key 10 held for 2 frames then released -> no event; key_state stays 0.
- Multi-key: keys 0 and 15 pressed together -> key_state bits 0 and 15 set; events 0 then 15 in that order; with 5 held, release of 0 yields only a code 0 release event.
- Overflow: FIFO_DEPTH=8, evt_ready=0, press and release 5 keys (10 events) -> fifo_count=8, overflow=1, the first 8 events are retained in order; ovf_clr pulse -> overflow=0; draining yields the 8 events.
- Reset mid-operation: assert rst during serial update with 3 events queued -> next cycle fifo_count=0, evt_valid=0, key_state=0, col=all ones; a still-held key re-registers after DEBOUNCE frames.
